// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ready handshake and drives
// the IF/ID register, with a one-entry skid buffer for words fetched while decode stalls.
module if_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] BUBBLE_INS = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic [15:0] PC_out,
    output logic        valid_out
);

    // state | meaning
    // IDLE  | one request-free cycle after reset
    // FETCH | request outstanding at pc
    // HOLD  | word parked in skid while decode stalls; no request
    // DRAIN | finishing an abandoned request; response is dropped, then jump to pend_pc
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pend_pc_q, pend_pc_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pc_q, skid_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    logic        req;
    logic        xfer;
    logic        bubble;
    logic [15:0] pc_inc;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        bubble       = 1'b0;

        req    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        xfer   = req && imem_rdy;
        pc_inc = pc_q + 16'd1;

        if (redirect) begin
            // Flush wins over stall: the IF/ID entry and any parked word are stale.
            bubble       = 1'b1;
            skid_valid_d = 1'b0;
            if (req && !imem_rdy) begin
                pend_pc_d = redirect_pc;
                state_d   = ST_DRAIN;
            end else begin
                pc_d    = redirect_pc;
                state_d = ST_FETCH;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    bubble  = !hazard;
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (xfer) begin
                        pc_d = pc_inc;
                        if (!hazard) begin
                            instr_d  = imem_data;
                            pc_out_d = pc_inc;
                            valid_d  = 1'b1;
                        end else begin
                            skid_instr_d = imem_data;
                            skid_pc_d    = pc_inc;
                            skid_valid_d = 1'b1;
                            state_d      = ST_HOLD;
                        end
                    end else begin
                        bubble = !hazard;
                    end
                end
                ST_HOLD: begin
                    if (!hazard) begin
                        instr_d      = skid_instr_q;
                        pc_out_d     = skid_pc_q;
                        valid_d      = skid_valid_q;
                        skid_valid_d = 1'b0;
                        state_d      = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    bubble = !hazard;
                    if (imem_rdy) begin
                        pc_d    = pend_pc_q;
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (bubble) begin
            valid_d = 1'b0;
            instr_d = BUBBLE_INS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            skid_instr_q <= BUBBLE_INS;
            skid_pc_q    <= 16'h0000;
            skid_valid_q <= 1'b0;
            instr_q      <= BUBBLE_INS;
            pc_out_q     <= 16'h0000;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
        end
    end

    // In DRAIN pc has not moved yet, so the address stays at the abandoned word.
    assign imem_req  = req;
    assign imem_addr = pc_q;
    assign instr_out = instr_q;
    assign PC_out    = pc_out_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory returns 16'hA000+addr; a scoreboard of fetched words is
// consumed whenever decode takes a valid IF/ID entry, plus directed scenario checks.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic [15:0] PC_out;
    logic        valid_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] sb_q[$];
    logic        sb_en   = 1'b0;
    logic        m_drain = 1'b0;
    logic [15:0] m_addr  = 16'h0000;
    logic [15:0] m_pend  = 16'h0000;

    always #5 clk = ~clk;

    assign imem_data = 16'hA000 + imem_addr;

    if_fetch_unit #(.RESET_PC(16'h0000), .BUBBLE_INS(16'h0000)) dut (
        .clk(clk), .rst(rst), .hazard(hazard), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_data(imem_data), .instr_out(instr_out),
        .PC_out(PC_out), .valid_out(valid_out)
    );

    // One clock: drive at negedge, score pre-edge outputs, advance the model, check post-edge.
    task automatic tick(input logic hz, input logic rd, input logic [15:0] rpc, input logic rdy);
        logic        req_s;
        logic [15:0] p_instr, p_pc;
        logic        p_valid;
        logic [31:0] exp;
        hazard = hz; redirect = rd; redirect_pc = rpc; imem_rdy = rdy;
        #1;
        req_s = imem_req;
        p_instr = instr_out; p_pc = PC_out; p_valid = valid_out;
        if (sb_en) begin
            if (imem_req) begin
                n_checks++;
                if (imem_addr !== m_addr)
                    $display("FAIL imem_addr: got %h expected %h", imem_addr, m_addr);
                else n_pass++;
            end
            if (valid_out && !hz && !rd) begin
                n_checks++;
                if (sb_q.size() == 0)
                    $display("FAIL sb_unexpected: got %h/%h expected no valid entry", instr_out, PC_out);
                else begin
                    exp = sb_q.pop_front();
                    if ({instr_out, PC_out} !== exp)
                        $display("FAIL sb_entry: got %h/%h expected %h/%h",
                                 instr_out, PC_out, exp[31:16], exp[15:0]);
                    else n_pass++;
                end
            end
        end
        @(posedge clk);
        if (sb_en) begin
            if (rd) begin
                sb_q.delete();
                if (req_s && !rdy) begin
                    m_drain = 1'b1;
                    m_pend  = rpc;
                end else begin
                    m_drain = 1'b0;
                    m_addr  = rpc;
                end
            end else if (m_drain) begin
                if (rdy) begin
                    m_drain = 1'b0;
                    m_addr  = m_pend;
                end
            end else if (req_s && rdy) begin
                sb_q.push_back({16'(16'hA000 + m_addr), 16'(m_addr + 16'd1)});
                m_addr = m_addr + 16'd1;
            end
        end
        #1;
        if (sb_en) begin
            if (hz && !rd) begin
                n_checks++;
                if ({instr_out, PC_out, valid_out} !== {p_instr, p_pc, p_valid})
                    $display("FAIL stall_hold: got %h/%h/%b expected %h/%h/%b",
                             instr_out, PC_out, valid_out, p_instr, p_pc, p_valid);
                else n_pass++;
            end
            if (!valid_out) begin
                n_checks++;
                if (instr_out !== 16'h0000)
                    $display("FAIL bubble_instr: got %h expected 0000", instr_out);
                else n_pass++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(0, 0, 16'h0, 1);
        tick(0, 0, 16'h0, 1);
        n_checks++;
        if ({imem_req, imem_addr, valid_out, instr_out, PC_out} !== {1'b0, 16'h0, 1'b0, 16'h0, 16'h0})
            $display("FAIL reset_vals: got req=%b addr=%h v=%b i=%h pc=%h expected all zero",
                     imem_req, imem_addr, valid_out, instr_out, PC_out);
        else n_pass++;
        rst = 1'b0;
        sb_q.delete(); m_drain = 1'b0; m_addr = 16'h0000; sb_en = 1'b1;
        tick(0, 0, 16'h0, 1);
        n_checks++;
        if ({imem_req, valid_out} !== 2'b10)
            $display("FAIL first_req: got req=%b valid=%b expected req=1 valid=0", imem_req, valid_out);
        else n_pass++;
        tick(0, 0, 16'h0, 1);
        n_checks++;
        if ({valid_out, instr_out, PC_out} !== {1'b1, 16'hA000, 16'h0001})
            $display("FAIL first_instr: got %b/%h/%h expected 1/a000/0001", valid_out, instr_out, PC_out);
        else n_pass++;
        tick(0, 0, 16'h0, 1);
        n_checks++;
        if ({valid_out, instr_out, PC_out} !== {1'b1, 16'hA001, 16'h0002})
            $display("FAIL throughput: got %b/%h/%h expected 1/a001/0002", valid_out, instr_out, PC_out);
        else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 20 && imem_addr != 16'h0005; i++) tick(0, 0, 16'h0, 1);
        n_checks++;
        if ({imem_addr, instr_out, PC_out} !== {16'h0005, 16'hA004, 16'h0005})
            $display("FAIL stall_pre: got %h/%h/%h expected 0005/a004/0005", imem_addr, instr_out, PC_out);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 16'h0, 1);
            n_checks++;
            if ({imem_req, instr_out, PC_out} !== {1'b0, 16'hA004, 16'h0005})
                $display("FAIL stall_hold_req: got %b/%h/%h expected 0/a004/0005", imem_req, instr_out, PC_out);
            else n_pass++;
        end
        tick(0, 0, 16'h0, 1);
        n_checks++;
        if ({valid_out, instr_out, PC_out, imem_addr} !== {1'b1, 16'hA005, 16'h0006, 16'h0006})
            $display("FAIL stall_release: got %b/%h/%h/%h expected 1/a005/0006/0006",
                     valid_out, instr_out, PC_out, imem_addr);
        else n_pass++;
        tick(0, 0, 16'h0, 1);
    endtask

    task automatic test_wait_states();
        for (int n = 0; n < 3; n++) begin
            for (int w = 0; w < 2; w++) begin
                tick(0, 0, 16'h0, 0);
                n_checks++;
                if (valid_out !== 1'b0)
                    $display("FAIL wait_bubble: got %b expected 0", valid_out);
                else n_pass++;
            end
            tick(0, 0, 16'h0, 1);
            n_checks++;
            if (valid_out !== 1'b1)
                $display("FAIL wait_deliver: got %b expected 1", valid_out);
            else n_pass++;
        end
    endtask

    task automatic test_redirect_drain();
        logic [15:0] old_addr;
        old_addr = imem_addr;
        tick(0, 1, 16'h0040, 0);
        tick(0, 0, 16'h0, 0);
        n_checks++;
        if ({imem_req, imem_addr, valid_out} !== {1'b1, old_addr, 1'b0})
            $display("FAIL drain_hold: got %b/%h/%b expected 1/%h/0", imem_req, imem_addr, valid_out, old_addr);
        else n_pass++;
        tick(0, 0, 16'h0, 1);
        n_checks++;
        if ({imem_addr, valid_out} !== {16'h0040, 1'b0})
            $display("FAIL drain_done: got %h/%b expected 0040/0", imem_addr, valid_out);
        else n_pass++;
        tick(0, 0, 16'h0, 1);
        n_checks++;
        if ({valid_out, instr_out, PC_out} !== {1'b1, 16'hA040, 16'h0041})
            $display("FAIL drain_target: got %b/%h/%h expected 1/a040/0041", valid_out, instr_out, PC_out);
        else n_pass++;
    endtask

    task automatic test_redirect_hazard();
        tick(1, 0, 16'h0, 1);
        n_checks++;
        if (imem_req !== 1'b0)
            $display("FAIL skid_fill: got req=%b expected 0", imem_req);
        else n_pass++;
        tick(1, 1, 16'h0100, 1);
        n_checks++;
        if ({valid_out, instr_out, imem_req, imem_addr} !== {1'b0, 16'h0000, 1'b1, 16'h0100})
            $display("FAIL redir_hazard: got %b/%h/%b/%h expected 0/0000/1/0100",
                     valid_out, instr_out, imem_req, imem_addr);
        else n_pass++;
        tick(0, 0, 16'h0, 1);
        n_checks++;
        if ({valid_out, instr_out, PC_out} !== {1'b1, 16'hA100, 16'h0101})
            $display("FAIL redir_target: got %b/%h/%h expected 1/a100/0101", valid_out, instr_out, PC_out);
        else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        tick(0, 1, 16'hFFFF, 1);
        n_checks++;
        if (imem_addr !== 16'hFFFF)
            $display("FAIL wrap_addr: got %h expected ffff", imem_addr);
        else n_pass++;
        tick(0, 0, 16'h0, 1);
        n_checks++;
        if ({valid_out, instr_out, PC_out, imem_addr} !== {1'b1, 16'h9FFF, 16'h0000, 16'h0000})
            $display("FAIL wrap: got %b/%h/%h/%h expected 1/9fff/0000/0000",
                     valid_out, instr_out, PC_out, imem_addr);
        else n_pass++;
        tick(0, 1, 16'h0200, 0);
        n_checks++;
        if ({imem_req, valid_out} !== 2'b10)
            $display("FAIL pre_rst_drain: got req=%b valid=%b expected 1/0", imem_req, valid_out);
        else n_pass++;
        rst = 1'b1;
        sb_en = 1'b0;
        tick(0, 0, 16'h0, 0);
        n_checks++;
        if ({imem_req, imem_addr, valid_out, instr_out, PC_out} !== {1'b0, 16'h0, 1'b0, 16'h0, 16'h0})
            $display("FAIL rst_mid_drain: got req=%b addr=%h v=%b i=%h pc=%h expected all zero",
                     imem_req, imem_addr, valid_out, instr_out, PC_out);
        else n_pass++;
        rst = 1'b0;
        tick(0, 0, 16'h0, 1);
    endtask

    initial begin
        rst = 1'b1; hazard = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; imem_rdy = 1'b1;
        @(negedge clk);
        test_reset();
        test_stall();
        test_wait_states();
        test_redirect_drain();
        test_redirect_hazard();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
